// File: rtl/reflex_pkg.sv
// Shared reflex-game constants: screen geometry, HUD and grid sizes, LFSR taps,
// state encoding for the target generator, and small geometry helpers.
package reflex_pkg;

    localparam int SCR_W_DEF   = 640;
    localparam int SCR_H_DEF   = 480;
    localparam int BALL_DEF    = 40;
    localparam int TOP_BAR_DEF = 40;
    localparam int SIDE_DEF    = 10;
    localparam int GRID_DEF    = 10;
    localparam int COORD_W     = 10;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } tg_state_e;

    function automatic int grid_count(input int lo, input int hi, input int step);
        return (hi - lo) / step + 1;
    endfunction

    // One extra bit keeps the magnitude exact for any pair of coordinates.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

endpackage

// File: rtl/target_gen_if.sv
// Request/commit bundle between game control (master) and the target generator (slave).
interface target_gen_if
    import reflex_pkg::*;
#(
    parameter int N_TGT = 4,
    parameter int IDXW  = (N_TGT > 1) ? $clog2(N_TGT) : 1
);
    logic                     req;
    logic [IDXW-1:0]          req_idx;
    logic [N_TGT-1:0]         clr;
    logic                     busy;
    logic                     valid;
    logic [IDXW-1:0]          valid_idx;
    logic                     overlap;
    logic [N_TGT-1:0]         active;
    logic [N_TGT*COORD_W-1:0] pos_x;
    logic [N_TGT*COORD_W-1:0] pos_y;

    modport master (
        output req, req_idx, clr,
        input  busy, valid, valid_idx, overlap, active, pos_x, pos_y
    );

    modport slave (
        input  req, req_idx, clr,
        output busy, valid, valid_idx, overlap, active, pos_x, pos_y
    );
endinterface

// File: rtl/lfsr_gen.sv
// Free-running right-shift Galois LFSR; a zero seed is replaced so it never locks up.
module lfsr_gen #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = 16'hB400,
    parameter logic [W-1:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] lfsr_o
);
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(16'hACE1) : SEED;

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        if (!en_i) begin
            lfsr_d = lfsr_q;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/target_gen.sv
// Multi-slot target position generator: draws LFSR candidates on request,
// rejects out-of-field or overlapping ones, and commits the slot position.
module target_gen
    import reflex_pkg::*;
#(
    parameter int                SCR_W   = SCR_W_DEF,
    parameter int                SCR_H   = SCR_H_DEF,
    parameter int                BALL    = BALL_DEF,
    parameter int                TOP_BAR = TOP_BAR_DEF,
    parameter int                SIDE    = SIDE_DEF,
    parameter int                GRID    = GRID_DEF,
    parameter int                N_TGT   = 4,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_SEED,
    parameter int                MAX_TRY = 16
) (
    input  logic        clk,
    input  logic        rst,
    target_gen_if.slave bus
);
    localparam int X_MIN = SIDE;
    localparam int X_MAX = SCR_W - SIDE - BALL;
    localparam int Y_MIN = TOP_BAR;
    localparam int Y_MAX = SCR_H - SIDE - BALL;
    localparam int NX    = grid_count(X_MIN, X_MAX, GRID);
    localparam int NY    = grid_count(Y_MIN, Y_MAX, GRID);
    localparam int XB    = $clog2(NX);
    localparam int YB    = $clog2(NY);
    localparam int IDXW  = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int TW    = $clog2(MAX_TRY + 1);

    tg_state_e                state_q;
    logic [IDXW-1:0]          idx_q;
    logic [TW-1:0]            tries_q;
    logic [COORD_W-1:0]       px_q;
    logic [COORD_W-1:0]       py_q;
    logic                     busy_q;
    logic                     valid_q;
    logic [IDXW-1:0]          valid_idx_q;
    logic                     overlap_q;
    logic [N_TGT-1:0]         active_q;
    logic [N_TGT*COORD_W-1:0] pos_x_q;
    logic [N_TGT*COORD_W-1:0] pos_y_q;

    logic [LFSR_W-1:0]  lfsr_s;
    logic               lfsr_unused_s;
    logic [XB-1:0]      cx_s;
    logic [YB-1:0]      cy_s;
    logic               in_range_s;
    logic [COORD_W-1:0] cand_x_s;
    logic [COORD_W-1:0] cand_y_s;
    logic               last_try_s;
    logic [N_TGT-1:0]   hit_s;
    logic               coll_s;
    logic               go_commit_s;
    logic               forced_s;
    logic [N_TGT-1:0]   clr_eff_s;

    lfsr_gen #(
        .W    (LFSR_W),
        .TAPS (LFSR_W'(LFSR_TAPS)),
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .lfsr_o (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s;

    // One comparator per slot against the registered candidate.
    for (genvar j = 0; j < N_TGT; j++) begin : g_cmp
        logic [COORD_W:0] dx_s;
        logic [COORD_W:0] dy_s;
        assign dx_s     = abs_diff(px_q, pos_x_q[j*COORD_W +: COORD_W]);
        assign dy_s     = abs_diff(py_q, pos_y_q[j*COORD_W +: COORD_W]);
        assign hit_s[j] = active_q[j] && (idx_q != IDXW'(j)) &&
                          (dx_s < (COORD_W+1)'(BALL)) && (dy_s < (COORD_W+1)'(BALL));
    end

    always_comb begin
        cx_s        = lfsr_s[XB-1:0];
        cy_s        = lfsr_s[LFSR_W-1 -: YB];
        in_range_s  = (int'(cx_s) < NX) && (int'(cy_s) < NY);
        cand_x_s    = COORD_W'(X_MIN + int'(cx_s) * GRID);
        cand_y_s    = COORD_W'(Y_MIN + int'(cy_s) * GRID);
        last_try_s  = (int'(tries_q) + 1) >= MAX_TRY;
        coll_s      = |hit_s;
        go_commit_s = ((state_q == ST_DRAW) && !in_range_s && last_try_s) ||
                      ((state_q == ST_CHECK) && (!coll_s || last_try_s));
        forced_s    = go_commit_s && !((state_q == ST_CHECK) && !coll_s);
        // The slot just committed cannot be cleared while its valid pulse is out.
        if (state_q == ST_COMMIT) begin
            clr_eff_s = bus.clr & ~(N_TGT'(1'b1) << idx_q);
        end else begin
            clr_eff_s = bus.clr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tries_q     <= '0;
            px_q        <= '0;
            py_q        <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            valid_idx_q <= '0;
            overlap_q   <= 1'b0;
            active_q    <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
        end else begin
            active_q <= active_q & ~clr_eff_s;
            case (state_q)
                ST_IDLE: begin
                    valid_q   <= 1'b0;
                    overlap_q <= 1'b0;
                    if (bus.req) begin
                        idx_q   <= bus.req_idx;
                        tries_q <= '0;
                        px_q    <= COORD_W'(X_MIN);
                        py_q    <= COORD_W'(Y_MIN);
                        busy_q  <= 1'b1;
                        state_q <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (in_range_s) begin
                        px_q    <= cand_x_s;
                        py_q    <= cand_y_s;
                        state_q <= ST_CHECK;
                    end else if (go_commit_s) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (go_commit_s) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                        state_q <= ST_DRAW;
                    end
                end
                ST_COMMIT: begin
                    valid_q   <= 1'b0;
                    overlap_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // Commit lands on entry to COMMIT so positions and valid appear together.
            if (go_commit_s) begin
                valid_q                               <= 1'b1;
                valid_idx_q                           <= idx_q;
                overlap_q                             <= forced_s;
                pos_x_q[idx_q*COORD_W +: COORD_W]     <= px_q;
                pos_y_q[idx_q*COORD_W +: COORD_W]     <= py_q;
                active_q[idx_q]                       <= 1'b1;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.valid_idx = valid_idx_q;
    assign bus.overlap   = overlap_q;
    assign bus.active    = active_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
endmodule

// File: tb/tb_target_gen.sv
// Scoreboard bench for target_gen: a default instance plus a forced-accept instance.
module tb_target_gen;
    import reflex_pkg::*;

    localparam int          N    = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int idx;
        int t;
        bit no_ovl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   commits_a = 0;
    int   commits_b = 0;
    int   last_valid_cyc_a = 0;
    bit   any_ovl_b = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    target_gen_if #(.N_TGT(N)) bus_a ();
    target_gen_if #(.N_TGT(N)) bus_b ();

    target_gen #(.N_TGT(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    target_gen #(.N_TGT(N), .BALL(200), .MAX_TRY(1)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference Galois LFSR, mask 0xB400, right shift.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        int px, py, lat;
        if (!rst && bus_a.valid) begin
            commits_a++;
            last_valid_cyc_a = cyc;
            if (sb_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_valid: got idx %0d expected no valid", bus_a.valid_idx);
            end else begin
                e   = sb_a.pop_front();
                lat = cyc - e.t;
                px  = int'(bus_a.pos_x[e.idx*10 +: 10]);
                py  = int'(bus_a.pos_y[e.idx*10 +: 10]);
                chk("a_valid_idx", bus_a.valid_idx, e.idx);
                chk("a_lat_min3", lat >= 3, 1);
                chk("a_lat_max34", lat <= 34, 1);
                chk("a_active_bit", bus_a.active[e.idx], 1);
                chk("a_px_range_grid", (px >= 10 && px <= 590 && px % 10 == 0), 1);
                chk("a_py_range_grid", (py >= 40 && py <= 430 && py % 10 == 0), 1);
                if (e.no_ovl) chk("a_overlap_zero", bus_a.overlap, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && bus_b.valid) begin
            commits_b++;
            if (bus_b.overlap) any_ovl_b = 1'b1;
            if (sb_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_valid: got idx %0d expected no valid", bus_b.valid_idx);
            end else begin
                e = sb_b.pop_front();
                chk("b_valid_idx", bus_b.valid_idx, e.idx);
                chk("b_lat_max4", (cyc - e.t) <= 4, 1);
            end
        end
    end

    task automatic request(input int which, input int idx, input bit no_ovl);
        exp_t e;
        @(negedge clk);
        e.idx    = idx;
        e.t      = cyc;
        e.no_ovl = no_ovl;
        if (which == 0) begin
            bus_a.req     = 1'b1;
            bus_a.req_idx = 2'(idx);
            sb_a.push_back(e);
        end else begin
            bus_b.req     = 1'b1;
            bus_b.req_idx = 2'(idx);
            sb_b.push_back(e);
        end
        @(negedge clk);
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget, input string name);
        int n = 0;
        while (((which == 0) ? bus_a.busy : bus_b.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (which == 0) ? bus_a.busy : bus_b.busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, n, ok, dx, dy;
        logic [9:0] px0;
        bus_a.req = 1'b0; bus_a.req_idx = '0; bus_a.clr = '0;
        bus_b.req = 1'b0; bus_b.req_idx = '0; bus_b.clr = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_valid", bus_a.valid, 0);
        chk("rst_valid_idx", bus_a.valid_idx, 0);
        chk("rst_overlap", bus_a.overlap, 0);
        chk("rst_active", bus_a.active, 0);
        chk("rst_pos_x", bus_a.pos_x, 0);
        chk("rst_pos_y", bus_a.pos_y, 0);
        chk("rst_lfsr_seed", dut.u_lfsr.lfsr_q, 16'hACE1);
        rst = 1'b0;
        @(negedge clk);
        chk("lfsr_step1", dut.u_lfsr.lfsr_q, 16'hE270);
        @(negedge clk);
        chk("lfsr_step2", dut.u_lfsr.lfsr_q, 16'h7138);

        // Forced accept: big balls, a single try per request.
        for (int i = 0; i < N; i++) begin
            request(1, i, 1'b0);
            wait_idle(1, 20, "b_fill_timeout");
        end
        chk("b_active_all", bus_b.active, 4'b1111);
        chk("b_any_overlap", any_ovl_b, 1);
        chk("b_commit_count", commits_b, 4);

        // First request and fill of the default instance.
        request(0, 0, 1'b1);
        chk("a_busy_after_req", bus_a.busy, 1);
        wait_idle(0, 40, "a_first_timeout");
        chk("a_busy_drop", cyc - last_valid_cyc_a, 1);
        chk("a_active_first", bus_a.active, 4'b0001);
        for (int i = 1; i < N; i++) begin
            request(0, i, 1'b1);
            wait_idle(0, 40, "a_fill_timeout");
        end
        chk("a_active_all", bus_a.active, 4'b1111);
        ok = 1;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                dx = int'(bus_a.pos_x[i*10 +: 10]) - int'(bus_a.pos_x[j*10 +: 10]);
                dy = int'(bus_a.pos_y[i*10 +: 10]) - int'(bus_a.pos_y[j*10 +: 10]);
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                if (dx < 40 && dy < 40) ok = 0;
            end
        end
        chk("a_pairs_separated", ok, 1);
        chk("lfsr_vs_model", dut.u_lfsr.lfsr_q, m_lfsr);

        // Request while busy: the second request must be dropped.
        c0 = commits_a;
        @(negedge clk);
        sb_a.push_back('{idx: 1, t: cyc, no_ovl: 1'b0});
        bus_a.req = 1'b1; bus_a.req_idx = 2'd1;
        @(negedge clk);
        bus_a.req_idx = 2'd2;
        @(negedge clk);
        bus_a.req = 1'b0;
        wait_idle(0, 40, "a_busy_req_timeout");
        repeat (5) @(negedge clk);
        chk("a_single_valid", commits_a - c0, 1);

        // clr on the committing slot during COMMIT, then one cycle later.
        request(0, 0, 1'b0);
        n = 0;
        while (!bus_a.valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("a_commit_seen", bus_a.valid, 1);
        px0 = bus_a.pos_x[9:0];
        bus_a.clr = 4'b0001;
        @(negedge clk);
        chk("a_commit_beats_clr", bus_a.active[0], 1);
        @(negedge clk);
        bus_a.clr = 4'b0000;
        chk("a_clr_later", bus_a.active[0], 0);
        chk("a_clr_keeps_pos", bus_a.pos_x[9:0], px0);

        // Reset in the cycle after a request aborts the search.
        c0 = commits_a;
        request(0, 3, 1'b0);
        rst = 1'b1;
        sb_a.delete();
        sb_b.delete();
        @(negedge clk);
        chk("mid_rst_busy", bus_a.busy, 0);
        chk("mid_rst_valid", bus_a.valid, 0);
        chk("mid_rst_active", bus_a.active, 0);
        chk("mid_rst_lfsr", dut.u_lfsr.lfsr_q, 16'hACE1);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_valid", commits_a - c0, 0);
        chk("mid_rst_lfsr_model", dut.u_lfsr.lfsr_q, m_lfsr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/target_gen.md
# target_gen

Parametrised multi-target position generator for the reflex game. It holds up to `N_TGT` simultaneous ball targets and produces a fresh grid-aligned position for one target on request. Candidates come from a free-running LFSR and are rejected if they fall outside the playfield or overlap another active target. It sits between the game-control FSM (requests, hits) and the VGA drawing logic (positions, active mask).

## Interface

Parameters:
- `SCR_W`, 640: screen width, px
- `SCR_H`, 480: screen height, px
- `BALL`, 40: square target size, px
- `TOP_BAR`, 40: reserved HUD height, px; no target top edge above it
- `SIDE`, 10: left/right/bottom margin, px
- `GRID`, 10: position step, px
- `N_TGT`, 4: number of target slots (≥1)
- `LFSR_W`, 16: LFSR width
- `SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'hACE1
- `MAX_TRY`, 16: candidate attempts before forced accept

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `req` in 1: one-cycle request for a new position
- `req_idx` in `IDXW` = max(1, clog2(`N_TGT`)): slot to (re)place
- `clr` in `N_TGT`: one-hot or multi-hot; deactivates the flagged slots (hit or timeout)
- `busy` out 1: search in progress
- `valid` out 1: one-cycle pulse when a slot is committed
- `valid_idx` out `IDXW`: slot committed with `valid`
- `overlap` out 1: with `valid`, high if the commit was forced after `MAX_TRY`
- `active` out `N_TGT`: slot-holds-target mask
- `pos_x` out `N_TGT`*10: flattened left edges, slot i at bits [10i+9:10i]
- `pos_y` out `N_TGT`*10: flattened top edges

## Operation

Derived constants:
- `X_MIN`=`SIDE`, `X_MAX`=`SCR_W`-`SIDE`-`BALL`; `Y_MIN`=`TOP_BAR`, `Y_MAX`=`SCR_H`-`SIDE`-`BALL`.
- `NX`=(`X_MAX`-`X_MIN`)/`GRID`+1 and `NY`=(`Y_MAX`-`Y_MIN`)/`GRID`+1. Defaults: 10..590 gives NX=59; 40..430 gives NY=40.
- `XB`=clog2(`NX`), `YB`=clog2(`NY`).

LFSR:
- Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400) at the default width.
- Advances every cycle, including while idle, so player timing adds entropy.

FSM states IDLE, DRAW, CHECK, COMMIT:
- **IDLE:** on `req` latch `req_idx` and clear the try counter, then go to DRAW. `req` is ignored while `busy`.
- **DRAW:**
  - `cx` = `lfsr`[XB-1:0]; `cy` = `lfsr`[LFSR_W-1 -: YB].
  - If `cx`≥`NX` or `cy`≥`NY`: increment tries, stay in DRAW.
  - Otherwise register `px`=`X_MIN`+`cx`*`GRID` and `py`=`Y_MIN`+`cy`*`GRID`, then go to CHECK.
- **CHECK:**
  - A collision is any slot j≠idx with `active`[j] where |`px`-`pos_x`[j]|<`BALL` and |`py`-`pos_y`[j]|<`BALL`.
  - Compute absolute differences in 11-bit unsigned.
  - On collision: increment tries and return to DRAW. Otherwise go to COMMIT.
- **Forced accept:** if tries reaches `MAX_TRY` in DRAW or CHECK, go to COMMIT with `overlap`=1. The last in-range candidate is used; if none was in range, use (`X_MIN`,`Y_MIN`).
- **COMMIT:** write `pos_x`/`pos_y`[idx], set `active`[idx], pulse `valid` with `valid_idx`=idx, then return to IDLE.

Boundary and simultaneity rules:
- A slot being replaced (idx) is excluded from its own collision check.
- `clr` applies every cycle. If `clr`[idx] and COMMIT fall in the same cycle, COMMIT wins.
- A `clr` of a slot during CHECK takes effect from the next CHECK evaluation.
- Re-requesting an already active slot moves it.

## Timing

- **Reset values:** `busy`=0, `valid`=0, `valid_idx`=0, `overlap`=0, `active`=0, all `pos_x`/`pos_y`=0, FSM=IDLE, `lfsr`=`SEED`.
- `rst` asserted mid-search aborts it with no `valid`.
- `busy` goes high in the cycle after `req` and drops in the cycle after `valid`.
- **Minimum latency:** `req` at cycle 0 gives `valid` at cycle 3 (DRAW 1, CHECK 2, COMMIT 3).
- **Maximum latency:** 2·`MAX_TRY`+2 cycles.
- Outputs are registered; positions update in the same cycle `valid` is high.

## Structure

- Shared package `reflex_pkg`:
  - screen, ball, HUD and grid constants
  - `COORD_W`=10
  - the LFSR tap mask
  - a function computing `NX`/`NY`
- One sub-module, `lfsr_gen` (parameters `W`, `TAPS`, `SEED`), which is free-running and has an enable tied high.
- FSM, collision comparator array (`N_TGT` parallel compares) and slot registers stay in `target_gen`.

## Test plan

- **Reset and first request:** hold `rst` 2 cycles, then `req` with idx 0. `valid` arrives at ≥3 cycles with `valid_idx`=0 and `active`=4'b0001. `pos_x`[0] must be in 10..590 and a multiple of 10; `pos_y`[0] must be in 40..430 and a multiple of 10.
- **Fill all slots:** request idx 0..3 back-to-back, each after the previous `valid`. `active`=4'b1111, `overlap`=0 on every commit, and no pair has both |dx|<40 and |dy|<40.
- **Forced accept:** `MAX_TRY`=1 with `BALL`=200 and `N_TGT`=4, fill the slots. At least one `valid` carries `overlap`=1, and latency never exceeds 4 cycles.
- **Request while busy:** issue a second `req` (idx 2) the cycle after the first. Only one `valid` occurs, with `valid_idx` equal to the first idx.
- **Clear/commit collision:** assert `clr`=4'b0001 in the COMMIT cycle of idx 0. `active`[0]=1 afterwards. A `clr`=4'b0001 one cycle later gives `active`[0]=0 while `pos_x`[0] is unchanged.
- **Reset mid-search:** assert `rst` in the cycle after `req`. There is no `valid`, `busy`=0 and `active`=0 the next cycle, and `lfsr` equals `SEED` again.
